ssd_scan_driver: RTL
====================

# ssd_scan_driver

Two-digit seven-segment scan driver for the Pmod SSD, downstream of the AXI-Lite seven-seg register logic. It accepts an 8-bit value (two hex digits) on a write strobe and stages it. It latches the staged value into a display shadow only at a frame boundary, so the two digits never tear. It time-multiplexes the shared segment bus by toggling `CAT` at a programmable refresh rate.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥1.
- `SEVEN_SEG_WIDTH`, default 7: segment bus width. Bit 0 = a … bit 6 = g.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: one-cycle write strobe.
- `wr_data` in 8: [3:0] is the right digit (slot 0), [7:4] is the left digit (slot 1).
- `en` in 1: display enable. 0 blanks the segments; scanning continues.
- `SEG` out `SEVEN_SEG_WIDTH`: segment drive, active-high (1 = lit).
- `CAT` out 1: digit select. 0 = right digit, 1 = left digit.
- `pending` out 1: a staged value is waiting for the next frame boundary.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Prescaler counts 0..`REFRESH_DIV`-1. At terminal count it wraps to 0 and toggles `CAT`.
- A frame is slot 0 followed by slot 1. The frame boundary is the `CAT` 1→0 toggle.
- Write: on `wr_en`, `staged` ← `wr_data` and `pending` ← 1. Back-to-back writes overwrite `staged`; the last write wins.
- At a frame boundary with `pending`=1: `shadow` ← `staged` and `pending` ← 0.
- Write coincident with a boundary: `shadow` takes the pre-write `staged` value; `staged` takes the new data; `pending` stays 1.
- `frame_tick` is high exactly in the cycle the boundary toggle occurs, whether or not a load happens.
- Decode of the selected shadow nibble, hex 0..F:
  - 0–7: 3F 06 5B 4F 66 6D 7D 07
  - 8–F: 7F 6F 77 7C 39 5E 79 71
- `en`=0: `SEG` = 0. `CAT`, prescaler, staging and loads all continue unaffected.
- `SEG` and `CAT` are registered together from next-state values. They always refer to the same slot, with no mismatch cycle.
- `rst` mid-operation: prescaler, `CAT`, `shadow`, `staged`, `pending` and `frame_tick` all clear on the next edge. A pending write is discarded.

## Timing
- Reset values:
  - `CAT`=0, `pending`=0, `frame_tick`=0.
  - `SEG`=0x00 during reset; 0x3F (digit 0) from the first cycle after reset if `en`=1.
- `CAT` first toggles `REFRESH_DIV` cycles after `rst` deasserts. Period is 2·`REFRESH_DIV`.
- With `REFRESH_DIV`=1, `CAT` toggles every cycle and the boundary falls every second cycle.
- `pending` rises the cycle after `wr_en`.
- New data is visible on `SEG` from the boundary cycle onward. Worst-case write-to-display latency is 2·`REFRESH_DIV` cycles.
- `en` to `SEG` latency: 1 cycle.
- Prescaler width is clog2(`REFRESH_DIV`), minimum 1 bit. No overflow is possible.

## Configuration
- `SSD_LZ_BLANK_EN` defined:
  - In slot 1, if `shadow`[7:4]==0, `SEG`=0 (left digit blank).
  - Value 0x00 shows blank on the left and "0" on the right.
- `SSD_LZ_BLANK_EN` undefined: the left digit always decodes normally, so 0x05 shows "05".

## Structure
- Package `ssd_pkg` holds:
  - `SEG_OFF` constant.
  - The 16-entry hex-to-segment table/function.
  - Slot enum (`SLOT_RIGHT`=0, `SLOT_LEFT`=1).
- Sub-module `ssd_prescaler` takes `clk`, `rst`, `REFRESH_DIV` and emits a one-cycle `slot_tick` at terminal count.
- The top level holds the staging, shadow, `CAT` and `SEG` registers.

## Test plan
- **Reset and scan:** `REFRESH_DIV`=4, `en`=1, release reset → `CAT` pattern 0000 1111 0000…, `SEG`=0x3F in both slots, `frame_tick` every 8 cycles.
- **Write and frame load:** write 0xA7 mid slot 0 → `pending`=1 until the next 1→0 boundary. Then `SEG`=0x07 while `CAT`=0 and 0x77 while `CAT`=1. No frame mixes old and new digits.
- **Coincident write and boundary:** write 0x12, then write 0x34 in the boundary cycle → that frame shows 12, `pending` stays 1, and the next frame shows 34.
- **Enable gating:** `en`=0 for 10 cycles → `SEG`=0 one cycle later, `CAT` keeps toggling, and a write made meanwhile still loads at its boundary.
- **Reset mid-operation:** write 0x5C, assert `rst` before the boundary → `pending`=0, `CAT`=0, `SEG` shows 0x3F after release, and 5C is never displayed.
- **Leading-zero blank (`SSD_LZ_BLANK_EN`):**
  - Write 0x05 → slot 1 `SEG`=0, slot 0 `SEG`=0x6D.
  - Without the macro → slot 1 `SEG`=0x3F.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants, slot enum and hex-to-segment table for the SSD scan driver
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    SLOT_RIGHT = 1'b0,
    SLOT_LEFT  = 1'b1
  } slot_e;

  // Segment order: bit 0 = a ... bit 6 = g, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// rtl/ssd_prescaler.sv - digit-slot prescaler, pulses slot_tick on the last cycle of each slot
module ssd_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  assign slot_tick = (cnt == TERMINAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (slot_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - two-digit seven-segment scan driver with frame-synchronous shadow load
// Optional SSD_LZ_BLANK_EN blanks the left digit when its nibble is zero.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV     = 50000,
  parameter int SEVEN_SEG_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       en,
  output logic [SEVEN_SEG_WIDTH-1:0] SEG,
  output logic                       CAT,
  output logic                       pending,
  output logic                       frame_tick
);

  logic       slot_tick;
  slot_e      cat_q, cat_nxt;
  logic [7:0] staged, shadow, shadow_nxt;
  logic       boundary;
  logic [3:0] nibble;
  logic [6:0] seg_raw, seg_nxt;

  ssd_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick)
  );

  assign CAT = cat_q;

  // SEG is decoded from next-state slot and shadow so it lands in the same edge as CAT.
  always_comb begin
    cat_nxt = cat_q;
    if (slot_tick) begin
      cat_nxt = (cat_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
    end
    boundary   = slot_tick && (cat_q == SLOT_LEFT);
    shadow_nxt = (boundary && pending) ? staged : shadow;
    nibble     = (cat_nxt == SLOT_LEFT) ? shadow_nxt[7:4] : shadow_nxt[3:0];
    seg_raw    = hex_to_seg(nibble);
`ifdef SSD_LZ_BLANK_EN
    if ((cat_nxt == SLOT_LEFT) && (shadow_nxt[7:4] == 4'h0)) begin
      seg_raw = SEG_OFF;
    end
`endif
    seg_nxt = en ? seg_raw : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cat_q      <= SLOT_RIGHT;
      staged     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      SEG        <= '0;
    end else begin
      cat_q      <= cat_nxt;
      shadow     <= shadow_nxt;
      if (wr_en) begin
        staged <= wr_data;
      end
      // A write in the boundary cycle keeps pending set for the following frame.
      pending    <= wr_en || (pending && !boundary);
      frame_tick <= boundary;
      SEG        <= SEVEN_SEG_WIDTH'(seg_nxt);
    end
  end

endmodule
